demux_1_2_sched: RTL and testbench
==================================

# demux_1_2_sched

Packet-aware 1-to-2 stream dispatcher that sequences a 1-to-2 demultiplexer: it accepts a valid/ready beat stream, picks one of two output channels per packet, and holds that select for every beat until `in_last`. Each output has a one-entry registered stage, so full throughput is sustained and backpressure stays isolated per channel. It sits between a single producer and two consumers and replaces a free-running `sel` line with a handshaked, packet-safe scheduler.

## Interface
Parameters:
- `DATA_W`, 8, beat data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_data`  in  DATA_W  beat payload.
- `in_last`  in  1  final beat of packet.
- `in_dest`  in  1  requested channel; sampled on first beat only.
- `rr_mode`  in  1  1 = round-robin routing, 0 = `in_dest` routing. Ignored when `DEMUX_RR_EN` is undefined.
- `out0_valid`, `out1_valid`  out  1  channel beat valid.
- `out0_ready`, `out1_ready`  in  1  channel consumer ready.
- `out0_data`, `out1_data`  out  DATA_W  channel payload.
- `out0_last`, `out1_last`  out  1  channel last-beat flag.
- `sel`  out  1  channel currently locked, or chosen for the next packet.
- `busy`  out  1  high while in PKT state.
- `pkt_cnt0`, `pkt_cnt1`  out  8  completed packets routed per channel.

## Operation
- FSM states:
  - IDLE: no packet open.
  - PKT: packet open, `sel` locked.
- Channel choice in IDLE is combinational: `rr_mode ? rr_ptr : in_dest`. Registered `sel` shows this choice in IDLE.
- Transitions:
  - IDLE → PKT: accepted beat with `in_last`=0; `sel` latches the choice.
  - IDLE → IDLE: accepted beat with `in_last`=1 (single-beat packet).
  - PKT → IDLE: accepted beat with `in_last`=1.
- Packet completion: on every accepted `in_last` beat, `pkt_cnt[sel]` increments, wrapping 255→0. If round-robin is active, `rr_ptr` toggles.
- Output stage N:
  - Loads `in_data`/`in_last` and sets `outN_valid` on an accepted beat routed to N.
  - Clears `outN_valid` when `outN_ready` is high and no new load occurs.
  - Load and drain in the same cycle keeps valid=1 with the new beat.
- `in_ready = ~out_valid[ch] | out_ready[ch]`, where `ch` is the choice in IDLE or `sel` in PKT. The non-selected channel never affects `in_ready`.
- Head-of-line blocking is intended: a stalled channel stalls input even if the other channel is free. Beats are never reordered or dropped.
- `rr_mode` and `in_dest` changes during PKT are ignored until the next first beat.

## Timing
- Reset values: `in_ready`=1 (stages empty), all `outN_valid`/`outN_last`=0, `outN_data`=0, `sel`=0, `busy`=0, `pkt_cnt0`=`pkt_cnt1`=0, `rr_ptr`=0, state IDLE.
- Latency: a beat accepted at edge k is presented on its channel from edge k onward (one register stage).
- Throughput: one beat per cycle while the selected consumer holds ready high.
- `in_ready` has a combinational path from `outN_ready`. All other outputs are registered.
- Counter and `rr_ptr` updates take effect on the edge that accepts the `in_last` beat. A single-beat packet updates them without `busy` ever rising.
- Reset asserted mid-packet:
  - Immediately clears state and outputs to reset values.
  - Buffered beats are discarded.
  - The next accepted beat is treated as a first beat.
- The AXI-style rule applies downstream: `outN_valid`/data/last are held stable while `outN_ready`=0.

## Configuration
- `DEMUX_RR_EN` defined:
  - Round-robin pointer and `rr_mode` are compiled in.
  - With `rr_mode`=1, packets alternate 0,1,0,1… starting from `rr_ptr` (0 after reset), regardless of `in_dest`.
  - With `rr_mode`=0, `rr_ptr` holds its value.
- `DEMUX_RR_EN` undefined:
  - No `rr_ptr` register; `rr_mode` is unused.
  - Routing is always by `in_dest`.

## Test plan
- Reset check: release `rst_n` → `in_ready`=1, all valids 0, counters 0, `sel`=0, `busy`=0.
- Dest routing, both consumers ready:
  - Stimulus: 3-beat packet (0x11, 0x22, 0x33 with last) with `in_dest`=1, then 1-beat 0x44 with `in_dest`=0.
  - Required: `out1` shows 0x11/0x22/0x33 on consecutive cycles, with `out1_last` on 0x33.
  - Required: `out0` shows 0x44 with last.
  - Required: `pkt_cnt1`=1, `pkt_cnt0`=1, `busy` high only during the 3-beat packet.
- Mid-packet lock:
  - Stimulus: toggle `in_dest` every beat of a 4-beat packet started with `in_dest`=0.
  - Required: all 4 beats go to `out0`; `out1_valid` stays 0.
- Backpressure:
  - Stimulus: hold `out0_ready`=0 with `out1_ready`=1, and send a packet to 0.
  - Required: first beat held on `out0`, `in_ready` drops to 0, `out1_valid` stays 0.
  - Release `out0_ready` → remaining beats stream with no loss and no duplication.
- Round-robin (`DEMUX_RR_EN`, `rr_mode`=1):
  - Stimulus: 4 single-beat packets, all with `in_dest`=1.
  - Required: channels 0,1,0,1; `pkt_cnt0`=`pkt_cnt1`=2.
  - Also cover counter wrap: 256 packets to channel 0 → `pkt_cnt0`=0.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 after beat 2 of a 5-beat packet.
  - Required: outputs clear asynchronously.
  - After release, a new packet with `in_dest`=1 routes to `out1` as a fresh packet.

Source files
------------

// File: rtl/demux_1_2_sched.sv
// Packet-aware 1-to-2 stream dispatcher with one registered stage per output channel.
// Optional round-robin routing is compiled in with `define DEMUX_RR_EN.
module demux_1_2_sched #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_dest,
    input  logic              rr_mode,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_last,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,
    output logic              sel,
    output logic              busy,
    output logic [7:0]        pkt_cnt0,
    output logic [7:0]        pkt_cnt1
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t state_q, state_d;
    logic   sel_q;
    logic   choice;
    logic   ch;
    logic   accept;
    logic   done;

`ifdef DEMUX_RR_EN
    logic rr_ptr_q;
    assign choice = rr_mode ? rr_ptr_q : in_dest;
`else
    logic unused_rr_mode;
    assign unused_rr_mode = rr_mode;
    assign choice         = in_dest;
`endif

    // The channel is only chosen on a first beat; inside a packet it stays locked.
    assign ch       = (state_q == IDLE) ? choice : sel_q;
    assign in_ready = ch ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
    assign accept   = in_valid & in_ready;
    assign done     = accept & in_last;
    assign sel      = sel_q;
    assign busy     = (state_q == PKT);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !in_last) state_d = PKT;
            PKT:     if (done)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= ch;
            if (done) begin
                if (ch) pkt_cnt1 <= pkt_cnt1 + 8'd1;
                else    pkt_cnt0 <= pkt_cnt0 + 8'd1;
            end
        end
    end

`ifdef DEMUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rr_ptr_q <= 1'b0;
        else if (done && rr_mode)  rr_ptr_q <= ~rr_ptr_q;
    end
`endif

    // Load wins over drain, so a simultaneous load and drain keeps valid with the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
        end else if (accept && !ch) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            out0_last  <= in_last;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
        end else if (accept && ch) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            out1_last  <= in_last;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1_2_sched.sv
// Self-checking bench for demux_1_2_sched: table-driven vectors plus reset, wrap and round-robin sequences.
module tb_demux_1_2_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last, in_dest, rr_mode;
    logic [7:0] in_data;
    logic       out0_valid, out0_ready, out0_last;
    logic       out1_valid, out1_ready, out1_last;
    logic [7:0] out0_data, out1_data;
    logic       sel, busy;
    logic [7:0] pkt_cnt0, pkt_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1_2_sched #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_dest(in_dest), .rr_mode(rr_mode),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
        .sel(sel), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       dest;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_l0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic       e_l1;
        logic       e_sel;
        logic       e_busy;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input logic v, input logic [7:0] d, input logic last, input logic dest,
                         input logic r0, input logic r1);
        in_valid = v; in_data = d; in_last = last; in_dest = dest;
        out0_ready = r0; out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready"},   in_ready,   1'b1);
        check({tag, " out0_valid"}, out0_valid, 1'b0);
        check({tag, " out1_valid"}, out1_valid, 1'b0);
        check({tag, " out0_data"},  out0_data,  8'h00);
        check({tag, " out1_last"},  out1_last,  1'b0);
        check({tag, " sel"},        sel,        1'b0);
        check({tag, " busy"},       busy,       1'b0);
        check({tag, " pkt_cnt0"},   pkt_cnt0,   8'd0);
        check({tag, " pkt_cnt1"},   pkt_cnt1,   8'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        rr_mode = 1'b0;
        rst_n   = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        //            v  d      last dest r0 r1 | rdy v0 d0     l0 v1 d1     l1 sel busy c0    c1
        // Dest routing: 3-beat packet to channel 1, then single-beat packet to channel 0.
        vecs[0]  = '{1, 8'h11, 0, 1, 1, 1,  1, 0, 8'h00, 0, 1, 8'h11, 0, 1, 1, 8'd0, 8'd0};
        vecs[1]  = '{1, 8'h22, 0, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h22, 0, 1, 1, 8'd0, 8'd0};
        vecs[2]  = '{1, 8'h33, 1, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h33, 1, 1, 0, 8'd0, 8'd1};
        vecs[3]  = '{1, 8'h44, 1, 0, 1, 1,  1, 1, 8'h44, 1, 0, 8'h33, 1, 0, 0, 8'd1, 8'd1};
        // Mid-packet lock: in_dest toggles but all four beats stay on channel 0.
        vecs[4]  = '{1, 8'hA1, 0, 0, 1, 1,  1, 1, 8'hA1, 0, 0, 8'h33, 1, 0, 1, 8'd1, 8'd1};
        vecs[5]  = '{1, 8'hA2, 0, 1, 1, 1,  1, 1, 8'hA2, 0, 0, 8'h33, 1, 0, 1, 8'd1, 8'd1};
        vecs[6]  = '{1, 8'hA3, 0, 0, 1, 1,  1, 1, 8'hA3, 0, 0, 8'h33, 1, 0, 1, 8'd1, 8'd1};
        vecs[7]  = '{1, 8'hA4, 1, 1, 1, 1,  1, 1, 8'hA4, 1, 0, 8'h33, 1, 0, 0, 8'd2, 8'd1};
        // Idle cycle drains channel 0; sel follows in_dest while idle.
        vecs[8]  = '{0, 8'h00, 0, 1, 1, 1,  1, 0, 8'hA4, 1, 0, 8'h33, 1, 1, 0, 8'd2, 8'd2 - 8'd1};
        // Backpressure on channel 0 blocks input even though channel 1 is free.
        vecs[9]  = '{1, 8'hB1, 0, 0, 0, 1,  1, 1, 8'hB1, 0, 0, 8'h33, 1, 0, 1, 8'd2, 8'd1};
        vecs[10] = '{1, 8'hB2, 0, 1, 0, 1,  0, 1, 8'hB1, 0, 0, 8'h33, 1, 0, 1, 8'd2, 8'd1};
        vecs[11] = '{1, 8'hB2, 0, 1, 0, 1,  0, 1, 8'hB1, 0, 0, 8'h33, 1, 0, 1, 8'd2, 8'd1};
        vecs[12] = '{1, 8'hB2, 0, 1, 1, 1,  1, 1, 8'hB2, 0, 0, 8'h33, 1, 0, 1, 8'd2, 8'd1};
        vecs[13] = '{1, 8'hB3, 1, 1, 1, 1,  1, 1, 8'hB3, 1, 0, 8'h33, 1, 0, 0, 8'd3, 8'd1};
        vecs[14] = '{0, 8'h00, 0, 1, 1, 1,  1, 0, 8'hB3, 1, 0, 8'h33, 1, 1, 0, 8'd3, 8'd1};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].last, vecs[i].dest, vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
            tick();
            check($sformatf("v%0d out0_valid", i), out0_valid, vecs[i].e_v0);
            check($sformatf("v%0d out0_data", i),  out0_data,  vecs[i].e_d0);
            check($sformatf("v%0d out0_last", i),  out0_last,  vecs[i].e_l0);
            check($sformatf("v%0d out1_valid", i), out1_valid, vecs[i].e_v1);
            check($sformatf("v%0d out1_data", i),  out1_data,  vecs[i].e_d1);
            check($sformatf("v%0d out1_last", i),  out1_last,  vecs[i].e_l1);
            check($sformatf("v%0d sel", i),        sel,        vecs[i].e_sel);
            check($sformatf("v%0d busy", i),       busy,       vecs[i].e_busy);
            check($sformatf("v%0d pkt_cnt0", i),   pkt_cnt0,   vecs[i].e_c0);
            check($sformatf("v%0d pkt_cnt1", i),   pkt_cnt1,   vecs[i].e_c1);
        end

        // Reset mid-packet: two beats of a 5-beat packet to channel 0, then async reset.
        drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("midpkt busy", busy, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        #3;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("fresh out1_valid", out1_valid, 1'b1);
        check("fresh out1_data",  out1_data,  8'hD1);
        check("fresh out0_valid", out0_valid, 1'b0);
        check("fresh busy",       busy,       1'b1);
        drive(1'b1, 8'hD2, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("fresh out1_data2", out1_data, 8'hD2);
        check("fresh out1_last",  out1_last, 1'b1);
        check("fresh pkt_cnt1",   pkt_cnt1,  8'd1);
        check("fresh pkt_cnt0",   pkt_cnt0,  8'd0);
        check("fresh busy end",   busy,      1'b0);

        // Counter wrap: 256 single-beat packets to channel 0.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, i[7:0], 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
            if (i == 254) check("wrap pkt_cnt0 255", pkt_cnt0, 8'd255);
        end
        check("wrap pkt_cnt0 0", pkt_cnt0, 8'd0);
        check("wrap pkt_cnt1",   pkt_cnt1, 8'd1);
        check("wrap busy",       busy,     1'b0);

`ifdef DEMUX_RR_EN
        // Round-robin: four single-beat packets all requesting channel 1 alternate 0,1,0,1.
        do_reset();
        rr_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b1);
            tick();
            check($sformatf("rr%0d out0_valid", i), out0_valid, (i % 2) == 0);
            check($sformatf("rr%0d out1_valid", i), out1_valid, (i % 2) == 1);
        end
        check("rr pkt_cnt0", pkt_cnt0, 8'd2);
        check("rr pkt_cnt1", pkt_cnt1, 8'd2);
        rr_mode = 1'b0;
`endif

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
